// File: rtl/fp32_pkg.sv
// Shared FP32 constants and accumulator state encoding.
// Zero-or-normal format only, truncation rounding, no NaN.
package fp32_pkg;

  localparam int FP32_BIAS = 127;
  localparam int EXP_MAX   = 255;
  localparam int SIGN_BIT  = 31;
  localparam int EXP_MSB   = 30;
  localparam int EXP_LSB   = 23;
  localparam int FRAC_MSB  = 22;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    ADD,
    NORM,
    DONE
  } acc_state_t;

  // exp==0 operands are flushed to an exact zero mantissa
  function automatic logic [25:0] fp32_mant(
    input logic [31:0] f
  );
    if (f[EXP_MSB:EXP_LSB] == 8'd0)
      return 26'd0;
    return {1'b1, f[FRAC_MSB:0], 2'b00};
  endfunction

endpackage

// File: rtl/fp32_lzc.sv
// 26-bit leading-zero counter; an all-zero input reports 26.
// Purely combinational, used by the accumulator normaliser.
module fp32_lzc (
  input  logic [25:0] i_val,
  output logic [4:0]  o_cnt
);

  always_comb begin
    o_cnt = 5'd26;
    for (int i = 0; i < 26; i++) begin
      if (i_val[i])
        o_cnt = 5'(25 - i);
    end
  end

endmodule

// File: rtl/fp32_accumulator.sv
// Sequential FP32 packet accumulator: align, add, normalise.
// One term per four cycles; result held until consumed.
module fp32_accumulator
  import fp32_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [CNT_W-1:0] out_count
);

  acc_state_t       r_state;
  logic [31:0]      r_term;
  logic             r_last;
  logic [31:0]      r_acc;
  logic [CNT_W-1:0] r_count;
  logic [25:0]      r_big_m;
  logic [25:0]      r_sml_m;
  logic [7:0]       r_exp;
  logic             r_sign_b;
  logic             r_sign_s;
  logic [26:0]      r_sum;
  logic             r_sign;

  logic        w_swap;
  logic [31:0] w_big;
  logic [31:0] w_sml;
  logic [7:0]  w_diff;
  logic [4:0]  w_sh;
  logic        w_same;
  logic        w_ge;
  logic [26:0] w_sum;
  logic        w_sign;
  logic [4:0]  w_lz;
  logic [25:0] w_norm_m;
  logic signed [9:0] w_e10;
  logic signed [9:0] w_lz10;
  logic signed [9:0] w_norm_e;
  logic [31:0] w_res;
  logic        w_unused;

  assign in_ready  = rst_n && (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign out_data  = r_acc;
  assign out_count = r_count;

  assign w_swap = r_term[EXP_MSB:EXP_LSB] >
                  r_acc[EXP_MSB:EXP_LSB];
  assign w_big  = w_swap ? r_term : r_acc;
  assign w_sml  = w_swap ? r_acc : r_term;
  assign w_diff = w_big[EXP_MSB:EXP_LSB] -
                  w_sml[EXP_MSB:EXP_LSB];
  assign w_sh   = (w_diff > 8'd26) ? 5'd26 : w_diff[4:0];

  assign w_same = (r_sign_b == r_sign_s);
  assign w_ge   = (r_big_m >= r_sml_m);

  always_comb begin
    w_sum  = {1'b0, r_big_m} + {1'b0, r_sml_m};
    w_sign = r_sign_b;
    if (!w_same) begin
      if (w_ge) begin
        w_sum = {1'b0, r_big_m} - {1'b0, r_sml_m};
      end else begin
        w_sum  = {1'b0, r_sml_m} - {1'b0, r_big_m};
        w_sign = r_sign_s;
      end
    end
  end

  fp32_lzc u_lzc (
    .i_val (r_sum[25:0]),
    .o_cnt (w_lz)
  );

  assign w_e10  = $signed({2'b00, r_exp});
  assign w_lz10 = $signed({5'b00000, w_lz});

  assign w_norm_m = r_sum[26] ? r_sum[26:1]
                              : (r_sum[25:0] << w_lz);
  assign w_norm_e = r_sum[26] ? (w_e10 + 10'sd1)
                              : (w_e10 - w_lz10);

  always_comb begin
    w_res = {r_sign, w_norm_e[7:0], w_norm_m[24:2]};
    if (r_sum == 27'd0)
      w_res = 32'h0000_0000;
    else if (w_norm_e <= 10'sd0)
      w_res = 32'h0000_0000;
    else if (w_norm_e >= 10'(EXP_MAX))
      w_res = {r_sign, 8'hFF, 23'h0};
  end

  assign w_unused = &{1'b0, w_norm_m[25], w_norm_m[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_term   <= '0;
      r_last   <= 1'b0;
      r_acc    <= '0;
      r_count  <= '0;
      r_big_m  <= '0;
      r_sml_m  <= '0;
      r_exp    <= '0;
      r_sign_b <= 1'b0;
      r_sign_s <= 1'b0;
      r_sum    <= '0;
      r_sign   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_term  <= in_data;
            r_last  <= in_last;
            r_count <= r_count + CNT_W'(1);
            r_state <= ALIGN;
          end
        end
        ALIGN: begin
          r_big_m  <= fp32_mant(w_big);
          r_sml_m  <= fp32_mant(w_sml) >> w_sh;
          r_exp    <= w_big[EXP_MSB:EXP_LSB];
          r_sign_b <= w_big[SIGN_BIT];
          r_sign_s <= w_sml[SIGN_BIT];
          r_state  <= ADD;
        end
        ADD: begin
          r_sum   <= w_sum;
          r_sign  <= w_sign;
          r_state <= NORM;
        end
        NORM: begin
          r_acc   <= w_res;
          r_state <= r_last ? DONE : IDLE;
        end
        DONE: begin
          if (out_ready) begin
            r_acc   <= '0;
            r_count <= '0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
